// File: rtl/conv_accumulator_if.sv
// conv_accumulator_if
//   Bundles the tap-input and result-output handshake of the convolution
//   accumulator. Parameter N is the sign-magnitude word width.
//
//   Handshake semantics (both sides):
//     - A tap transfers on a rising clk edge where acc_en && in_ready.
//     - A result transfers on a rising clk edge where res_valid && res_ready.
//       While res_valid is high and res_ready is low, res and res_ovr stay
//       stable.
//
//   Signals
//     acc_clr    master->slave  abort current window / pending result
//     acc_en     master->slave  product valid
//     prod       master->slave  sign-magnitude product (N bits)
//     prod_ovr   master->slave  multiplier overflow flag for prod
//     bias       master->slave  sign-magnitude bias, taken with the first tap
//     res_ready  master->slave  downstream accepts res
//     in_ready   slave->master  accumulator accepts a tap this cycle
//     res        slave->master  sign-magnitude window sum (N bits)
//     res_valid  slave->master  res holds a complete result
//     res_ovr    slave->master  saturation or any prod_ovr in the window
interface conv_accumulator_if #(
  parameter int N = 32
);
  logic         acc_clr;
  logic         acc_en;
  logic [N-1:0] prod;
  logic         prod_ovr;
  logic [N-1:0] bias;
  logic         in_ready;
  logic [N-1:0] res;
  logic         res_valid;
  logic         res_ovr;
  logic         res_ready;

  modport master (
    output acc_clr, acc_en, prod, prod_ovr, bias, res_ready,
    input  in_ready, res, res_valid, res_ovr
  );

  modport slave (
    input  acc_clr, acc_en, prod, prod_ovr, bias, res_ready,
    output in_ready, res, res_valid, res_ovr
  );
endinterface

// File: rtl/conv_accumulator.sv
// conv_accumulator
//   Sums TAPS sign-magnitude Q(N,Q) products plus a per-window bias into one
//   output pixel. Accumulation is two's complement on N+GUARD bits; the final
//   sum is saturated back to N-bit sign-magnitude and held until downstream
//   takes it.
//
//   Optional feature macro: ACC_RELU_EN -- when defined, negative window sums
//   are clamped to zero at the output stage.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     bus          conv_accumulator_if.slave (tap input + result output)
//     dbg_state_o  current FSM state (0 = ACCUM, 1 = HOLD)
module conv_accumulator #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int TAPS  = 9,
  parameter int GUARD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_accumulator_if.slave      bus,
  output logic                   dbg_state_o
);

  localparam int AW = N + GUARD;
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);
  // Largest magnitude representable in N-bit sign-magnitude.
  localparam logic [AW-1:0] MAX_MAG = {{(GUARD + 1){1'b0}}, {(N - 1){1'b1}}};

  // Q only fixes the binary point; it must lie inside the magnitude field.
  if (TAPS < 1 || Q > N - 1 || GUARD < 1) begin : g_bad_params
    $error("conv_accumulator: illegal parameter set");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tap_cnt_q, tap_cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            sticky_q, sticky_d;
  logic [N-1:0]    res_q, res_d;
  logic            res_valid_q, res_valid_d;
  logic            res_ovr_q, res_ovr_d;

  // Sign-magnitude to two's complement, sign-extended to AW. Negative zero
  // becomes zero because -0 == 0.
  function automatic logic [AW-1:0] sm2tc(input logic [N-1:0] x);
    logic [AW-1:0] mag;
    mag = {{(GUARD + 1){1'b0}}, x[N-2:0]};
    return x[N-1] ? -mag : mag;
  endfunction

  logic            first_tap;
  logic            last_tap;
  logic [AW-1:0]   sum;
  logic            sum_neg;
  logic [AW-1:0]   sum_abs;
  logic            sum_sat;
  logic            sticky_new;
  logic [N-1:0]    res_calc;
  logic            ovr_calc;

  assign first_tap  = (tap_cnt_q == '0);
  assign last_tap   = (tap_cnt_q == LAST_TAP);
  // The first tap folds the bias in, so a window never needs a separate
  // bias cycle.
  assign sum        = (first_tap ? sm2tc(bus.bias) : acc_q) + sm2tc(bus.prod);
  assign sticky_new = (first_tap ? 1'b0 : sticky_q) | bus.prod_ovr;
  assign sum_neg    = sum[AW-1];
  assign sum_abs    = sum_neg ? -sum : sum;
  assign sum_sat    = (sum_abs > MAX_MAG);

  // Output stage: saturate to N-bit sign-magnitude. A negative sum always has
  // a non-zero magnitude, so negative zero cannot be produced.
  always_comb begin
    res_calc = '0;
    ovr_calc = sticky_new;
`ifdef ACC_RELU_EN
    if (sum_neg) begin
      res_calc = '0;
      ovr_calc = sticky_new;
    end else if (sum_sat) begin
      res_calc = {1'b0, {(N - 1){1'b1}}};
      ovr_calc = 1'b1;
    end else begin
      res_calc = {1'b0, sum_abs[N-2:0]};
      ovr_calc = sticky_new;
    end
`else
    if (sum_sat) begin
      res_calc = {sum_neg, {(N - 1){1'b1}}};
      ovr_calc = 1'b1;
    end else begin
      res_calc = {sum_neg, sum_abs[N-2:0]};
      ovr_calc = sticky_new;
    end
`endif
  end

  // Next-state logic. acc_clr outranks both the tap path and the result
  // handshake; result data is left untouched by it.
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    res_ovr_d   = res_ovr_q;

    if (bus.acc_clr) begin
      tap_cnt_d   = '0;
      sticky_d    = 1'b0;
      res_valid_d = 1'b0;
      state_d     = ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.acc_en) begin
            acc_d = sum;
            if (last_tap) begin
              tap_cnt_d   = '0;
              sticky_d    = 1'b0;
              res_d       = res_calc;
              res_ovr_d   = ovr_calc;
              res_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              tap_cnt_d = tap_cnt_q + CW'(1);
              sticky_d  = sticky_new;
            end
          end
        end
        HOLD: begin
          // No bypass: taps are refused in the handshake cycle itself.
          if (bus.res_ready) begin
            res_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_ovr_q   <= res_ovr_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ovr   = res_ovr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// tb_conv_accumulator
//   Directed bench for conv_accumulator: a 9-tap instance (main) and a 1-tap
//   instance. Expected values are hand-computed constants.
module tb_conv_accumulator;

  logic clk;
  logic rst;
  logic st9;
  logic st1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] tp [9];
  logic [8:0]  tovr;

  conv_accumulator_if #(.N(32)) bus9 ();
  conv_accumulator_if #(.N(32)) bus1 ();

  conv_accumulator #(.N(32), .Q(16), .TAPS(9), .GUARD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus9.slave),
    .dbg_state_o (st9)
  );

  conv_accumulator #(.N(32), .Q(16), .TAPS(1), .GUARD(8)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1.slave),
    .dbg_state_o (st1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed tp[0..n-1]; bias is only meaningful on the first tap, so later taps
  // carry a junk bias that must be ignored.
  task automatic feed(input int n, input logic [31:0] b);
    for (int i = 0; i < n; i++) begin
      bus9.acc_en   = 1'b1;
      bus9.prod     = tp[i];
      bus9.prod_ovr = tovr[i];
      bus9.bias     = (i == 0) ? b : 32'h1234_5678;
      tick();
    end
    bus9.acc_en   = 1'b0;
    bus9.prod_ovr = 1'b0;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 9; i++) tp[i] = v;
    tovr = '0;
  endtask

  task automatic drain();
    bus9.res_ready = 1'b1;
    tick();
    bus9.res_ready = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] r, input logic v,
                           input logic o, input logic rdy);
    check({tag, ".res"},       bus9.res,              r);
    check({tag, ".res_valid"}, 32'(bus9.res_valid),   32'(v));
    check({tag, ".res_ovr"},   32'(bus9.res_ovr),     32'(o));
    check({tag, ".in_ready"},  32'(bus9.in_ready),    32'(rdy));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus9.acc_clr = 1'b0; bus9.acc_en = 1'b0; bus9.prod = '0; bus9.prod_ovr = 1'b0;
    bus9.bias = '0; bus9.res_ready = 1'b0;
    bus1.acc_clr = 1'b0; bus1.acc_en = 1'b0; bus1.prod = '0; bus1.prod_ovr = 1'b0;
    bus1.bias = '0; bus1.res_ready = 1'b0;
    fill(32'h0);
    tick();
    tick();
    check_res("reset", 32'h0, 1'b0, 1'b0, 1'b1);
    check("reset.state", 32'(st9), 32'h0);
    check("reset.t1_in_ready", 32'(bus1.in_ready), 32'h1);
    rst = 1'b0;

    // 1: reset mid-window, then 9 x 1.0
    fill(32'h0001_0000);
    feed(4, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_res("t1_rst", 32'h0, 1'b0, 1'b0, 1'b1);
    feed(9, 32'h0);
    check_res("t1_sum", 32'h0009_0000, 1'b1, 1'b0, 1'b0);
    check("t1.state_hold", 32'(st9), 32'h1);
    drain();
    check_res("t1_drain", 32'h0009_0000, 1'b0, 1'b0, 1'b1);

    // 2: -0.5 + 2.0 - 1.0 = 0.5, then a 5-cycle stall with acc_en pushing
    fill(32'h0);
    tp[0] = 32'h0002_0000;
    tp[1] = 32'h8001_0000;
    feed(8, 32'h8000_8000);
    check("t2.no_valid_before_last", 32'(bus9.res_valid), 32'h0);
    tp[0] = 32'h0;
    feed(1, 32'h1234_5678);
    check_res("t2_sum", 32'h0000_8000, 1'b1, 1'b0, 1'b0);
    bus9.acc_en = 1'b1;
    bus9.prod   = 32'h7FFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_res("t2_stall", 32'h0000_8000, 1'b1, 1'b0, 1'b0);
    end
    bus9.acc_en = 1'b0;
    drain();
    check_res("t2_drain", 32'h0000_8000, 1'b0, 1'b0, 1'b1);

    // 3: saturation both signs
    fill(32'h7FFF_FFFF);
    feed(9, 32'h0);
    check_res("t3_pos_sat", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    drain();
    fill(32'hFFFF_FFFF);
    feed(9, 32'h0);
`ifdef ACC_RELU_EN
    check_res("t3_neg_relu", 32'h0, 1'b1, 1'b0, 1'b0);
`else
    check_res("t3_neg_sat", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
    drain();

    // 4: sticky prod_ovr on tap 5, then a clean window
    fill(32'h0000_0100);
    tovr[4] = 1'b1;
    feed(9, 32'h0000_0005);
    check_res("t4_ovr", 32'h0000_0905, 1'b1, 1'b1, 1'b0);
    drain();
    fill(32'h0000_0100);
    feed(9, 32'h8000_0005);
    check_res("t4_clean", 32'h0000_08FB, 1'b1, 1'b0, 1'b0);
    drain();

    // 5: acc_clr on tap 6 drops the partial sum and that tap
    fill(32'h0000_1000);
    tovr[2] = 1'b1;
    feed(5, 32'h0000_0001);
    bus9.acc_clr  = 1'b1;
    bus9.acc_en   = 1'b1;
    bus9.prod     = 32'h0000_1000;
    tick();
    bus9.acc_clr  = 1'b0;
    bus9.acc_en   = 1'b0;
    check_res("t5_clr", 32'h0000_08FB, 1'b0, 1'b0, 1'b1);
    fill(32'h0000_0003);
    feed(9, 32'h0000_0001);
    check_res("t5_sum", 32'h0000_001C, 1'b1, 1'b0, 1'b0);
    bus9.acc_clr = 1'b1;
    tick();
    bus9.acc_clr = 1'b0;
    check_res("t5_clr_hold", 32'h0000_001C, 1'b0, 1'b0, 1'b1);

    // 6: cancelling taps with negative-zero bias -> plain zero
    fill(32'h0);
    tp[3] = 32'h0001_0000;
    tp[7] = 32'h8001_0000;
    feed(9, 32'h8000_0000);
    check_res("t6_zero", 32'h0, 1'b1, 1'b0, 1'b0);
    drain();
    fill(32'h0);
    feed(9, 32'h8000_0003);
`ifdef ACC_RELU_EN
    check_res("t6_neg_small", 32'h0, 1'b1, 1'b0, 1'b0);
`else
    check_res("t6_neg_small", 32'h8000_0003, 1'b1, 1'b0, 1'b0);
`endif
    drain();

    // TAPS=1 instance: every tap is a whole window
    bus1.bias   = 32'h0001_0000;
    bus1.prod   = 32'h0002_0000;
    bus1.acc_en = 1'b1;
    tick();
    bus1.acc_en = 1'b0;
    check("t1tap.res",      bus1.res,              32'h0003_0000);
    check("t1tap.valid",    32'(bus1.res_valid),   32'h1);
    check("t1tap.in_ready", 32'(bus1.in_ready),    32'h0);
    bus1.res_ready = 1'b1;
    tick();
    bus1.res_ready = 1'b0;
    check("t1tap.drain", 32'(bus1.res_valid), 32'h0);
    bus1.bias   = 32'h8003_0000;
    bus1.prod   = 32'h0001_0000;
    bus1.acc_en = 1'b1;
    tick();
    bus1.acc_en = 1'b0;
`ifdef ACC_RELU_EN
    check("t1tap.res_neg", bus1.res, 32'h0);
`else
    check("t1tap.res_neg", bus1.res, 32'h8002_0000);
`endif
    check("t1tap.valid2", 32'(bus1.res_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
